// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// id_ex_stage_pkg : ALU opcodes, forwarding selects and the EX register layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_reg_t;

  localparam ex_reg_t EX_BUBBLE = '0;

  // $0 is hardwired to zero, so a writer targeting it never supplies a value
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// id_ex_stage_if : ID-side inputs, forwarding sources and EX-side outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        stall;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_op;
  logic [31:0] ex_store_data;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  fwd_sel_e    rs_fwd_sel;
  fwd_sel_e    rt_fwd_sel;

  modport master (
    output flush, id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op, id_alu_src_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           mem_reg_write, mem_rd, mem_alu_result, wb_reg_write, wb_rd, wb_data,
    input  stall, alu_a, alu_b, alu_shamt, alu_op, ex_store_data, ex_valid,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           rs_fwd_sel, rt_fwd_sel
  );

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op, id_alu_src_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           mem_reg_write, mem_rd, mem_alu_result, wb_reg_write, wb_rd, wb_data,
    output stall, alu_a, alu_b, alu_shamt, alu_op, ex_store_data, ex_valid,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           rs_fwd_sel, rt_fwd_sel
  );

endinterface

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
// ============================================================================
// fwd_mux : picks EX/MEM, MEM/WB or register data for one source operand
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  wire logic [4:0]  src,
  input  wire logic [31:0] reg_data,
  input  wire logic        mem_reg_write,
  input  wire logic [4:0]  mem_rd,
  input  wire logic [31:0] mem_data,
  input  wire logic        wb_reg_write,
  input  wire logic [4:0]  wb_rd,
  input  wire logic [31:0] wb_data,
  output logic [31:0]      value,
  output fwd_sel_e         sel
);

  // The younger producer (EX/MEM) holds the newer value, so it is tried first
  always_comb begin
    sel   = FWD_REG;
    value = reg_data;
    if (fwd_hit(mem_reg_write, mem_rd, src)) begin
      sel   = FWD_MEM;
      value = mem_data;
    end else if (fwd_hit(wb_reg_write, wb_rd, src)) begin
      sel   = FWD_WB;
      value = wb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use stall, flush squash
//               and forwarded ALU operands
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input wire logic     clk,
  input wire logic     rst,
  id_ex_stage_if.slave bus
);

  ex_reg_t     r_ex;
  ex_reg_t     w_id_ex;
  logic        w_stall;
  logic        w_bubble;
  logic        w_use_hit;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  // A flush kills the consumer anyway, so it also suppresses the stall
  assign w_use_hit = (bus.id_use_rs && (bus.id_rs == r_ex.rd)) ||
                     (bus.id_use_rt && (bus.id_rt == r_ex.rd));
  assign w_stall   = bus.id_valid && r_ex.valid && r_ex.mem_read &&
                     (r_ex.rd != 5'd0) && w_use_hit && !bus.flush;
  assign w_bubble  = bus.flush || w_stall || !bus.id_valid;

  always_comb begin
    w_id_ex             = EX_BUBBLE;
    w_id_ex.valid       = 1'b1;
    w_id_ex.rs          = bus.id_rs;
    w_id_ex.rt          = bus.id_rt;
    w_id_ex.rd          = bus.id_rd;
    w_id_ex.rs_data     = bus.id_rs_data;
    w_id_ex.rt_data     = bus.id_rt_data;
    w_id_ex.imm         = bus.id_imm;
    w_id_ex.shamt       = bus.id_shamt;
    w_id_ex.alu_op      = bus.id_alu_op;
    w_id_ex.alu_src_imm = bus.id_alu_src_imm;
    w_id_ex.reg_write   = bus.id_reg_write;
    w_id_ex.mem_read    = bus.id_mem_read;
    w_id_ex.mem_write   = bus.id_mem_write;
    w_id_ex.mem_to_reg  = bus.id_mem_to_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= EX_BUBBLE;
    end else if (w_bubble) begin
      r_ex <= EX_BUBBLE;
    end else begin
      r_ex <= w_id_ex;
    end
  end

  fwd_mux u_fwd_rs (
    .src           (r_ex.rs),
    .reg_data      (r_ex.rs_data),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_alu_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .value         (w_rs_val),
    .sel           (bus.rs_fwd_sel)
  );

  fwd_mux u_fwd_rt (
    .src           (r_ex.rt),
    .reg_data      (r_ex.rt_data),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_alu_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .value         (w_rt_val),
    .sel           (bus.rt_fwd_sel)
  );

  assign bus.stall         = w_stall;
  assign bus.alu_a         = w_rs_val;
  assign bus.ex_store_data = w_rt_val;
  assign bus.alu_b         = r_ex.alu_src_imm ? r_ex.imm : w_rt_val;
  assign bus.alu_shamt     = r_ex.shamt;
  assign bus.alu_op        = r_ex.alu_op;
  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_rd         = r_ex.rd;
  assign bus.ex_reg_write  = r_ex.reg_write;
  assign bus.ex_mem_read   = r_ex.mem_read;
  assign bus.ex_mem_write  = r_ex.mem_write;
  assign bus.ex_mem_to_reg = r_ex.mem_to_reg;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS pipeline. It registers decoded instruction fields and control into the execute stage and detects load-use hazards, stalling the front end and inserting a bubble when one occurs. It squashes wrong-path instructions on a branch or jump flush. It produces the forwarded, immediate-selected operands `a`, `b` and `shamt` that drive the `alu` directly.

## Interface
- No parameters; ALU opcodes and forwarding-select codes come from `def.v`.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: taken branch or jump; discard the instruction currently in ID.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in 5 each: source registers and final destination register (already selected by ID).
- `id_use_rs`, `id_use_rt` in 1 each: instruction actually reads rs or rt.
- `id_rs_data`, `id_rt_data` in 32 each: register-file read data.
- `id_imm` in 32: extended immediate.
- `id_shamt` in 5: shift amount.
- `id_alu_op` in 4: ALU opcode.
- `id_alu_src_imm` in 1: operand b comes from the immediate.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1 each: control bits.
- `mem_reg_write` in 1, `mem_rd` in 5, `mem_alu_result` in 32: EX/MEM forwarding source.
- `wb_reg_write` in 1, `wb_rd` in 5, `wb_data` in 32: MEM/WB forwarding source.
- `stall` out 1: hold PC and IF/ID this cycle (combinational).
- `alu_a`, `alu_b` out 32 each: forwarded operands to the ALU (combinational).
- `alu_shamt` out 5, `alu_op` out 4: to the ALU (registered).
- `ex_store_data` out 32: forwarded rt value for `sw` (combinational).
- `ex_valid`, `ex_rd`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out: registered EX-stage fields passed on to EX/MEM.

## Operation
- **Internal state:** EX register holding valid, rs, rt, rd, rs_data, rt_data, imm, shamt, alu_op, alu_src_imm and the four control bits.
- **Load-use detection:** `stall` = `id_valid` & `ex_valid` & `ex_mem_read` & (`ex_rd` != 0) & ((`id_use_rs` & `id_rs`==`ex_rd`) | (`id_use_rt` & `id_rt`==`ex_rd`)) & !`flush`.
- **Register update priority at each clock edge:**
  1. `flush` or `stall` or !`id_valid`: load a bubble. valid=0 and all control bits 0; alu_op=0; data fields are don't-care and are held at 0.
  2. Otherwise: capture all `id_*` fields with valid=1.
- **Forwarding, applied independently to rs and rt:**
  - Select MEM when `mem_reg_write` & `mem_rd`!=0 & `mem_rd`==src.
  - Else select WB when `wb_reg_write` & `wb_rd`!=0 & `wb_rd`==src.
  - Else use the registered data.
  - MEM has priority over WB when both match.
  - Register $0 is never forwarded.
- **Operand outputs:**
  - `alu_a` = forwarded rs.
  - `ex_store_data` = forwarded rt.
  - `alu_b` = `ex_alu_src_imm` ? `ex_imm` : forwarded rt.
- A bubble holds no state that can write the register file or memory.

## Timing
- Reset drives every registered output and internal field to 0, including `ex_valid`=0 and `alu_op`=0. Combinational outputs then evaluate from those zeros: `stall`=0, and `alu_a`=`alu_b`=0 unless forwarding matches.
- ID to EX latency is 1 cycle.
- Forwarding, operand selection and `stall` settle combinationally within the same cycle.
- A load-use stall lasts exactly 1 cycle. On the following cycle the load is in MEM, so no further stall is raised for it.
- Simultaneous `flush` and `stall`: the flush wins, `stall` is 0, and a bubble is inserted.
- Reset asserted mid-stream clears the register asynchronously, with no partial update.

## Structure
- `def.v` holds the ALU opcodes and the forwarding-select constants `FWD_REG`, `FWD_MEM`, `FWD_WB`.
- Sub-module `fwd_mux` is instantiated twice, once for rs and once for rt. Inputs are src, the reg data and both forwarding sources. Outputs are the 32-bit value and the select code.
- The hazard compare and the EX register live in `id_ex_stage`.

## Test plan
- **Plain capture:** `addu` with id_rs_data=5, id_rt_data=7, alu_op=`ADDU`, then one clock → `alu_a`=5, `alu_b`=7, `ex_valid`=1.
- **MEM and WB forwarding:** ex_rs=8, mem_rd=8, mem_reg_write=1, mem_alu_result=0x1234, and wb_rd=8, wb_data=0x9 → `alu_a`=0x1234 (MEM wins). Then set mem_reg_write=0 → `alu_a`=0x9.
- **$0 guard:** src=0 with mem_rd=0, mem_reg_write=1, mem_alu_result=0xFF → `alu_a` = registered value 0.
- **Load-use:** `lw $3` in EX, ID `addu` with rs=3 → `stall`=1 for one cycle and the next EX is a bubble (valid=0, reg_write=0). The following cycle, with the load in MEM, `stall`=0 and the `addu` enters EX.
- **Flush:** `flush`=1 together with a load-use condition → `stall`=0 and the next EX is a bubble.
- **Reset:** assert `rst` mid-stream with ex_valid=1 → all registered outputs read 0 immediately, without waiting for a clock edge.
